// File: rtl/up_counter16_ctrl_pkg.sv
// Shared types and constants for the programmable up counter.
// State encoding plus default widths; no logic.
package up_counter_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_PRESCALE_W = 8;

  localparam logic [DEF_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [DEF_WIDTH-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/up_counter16_ctrl_if.sv
// Control/status bundle of the up counter; master drives commands, slave is the counter.
// Pure wiring, no latency; commands are single-cycle pulses with no backpressure.
interface up_counter16_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
);
  logic                  start;
  logic                  stop;
  logic                  one_shot;
  logic [WIDTH-1:0]      limit;
  logic [WIDTH-1:0]      cmp_val;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  running;
  logic                  done;
  logic                  tc;
  logic                  match;

  modport master (
    output start, stop, one_shot, limit, cmp_val, prescale,
    input  count, running, done, tc, match
  );

  modport slave (
    input  start, stop, one_shot, limit, cmp_val, prescale,
    output count, running, done, tc, match
  );
endinterface

// File: rtl/up_counter16_ctrl_prescaler.sv
// Tick generator: one tick every (i_prescale+1) cycles while i_run is high.
// Combinational tick from a registered divider; no backpressure.
module up_counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_div;
  logic                  w_hit;

  // >= rather than == so lowering prescale mid-run ticks at once instead of
  // running the divider all the way around.
  assign w_hit  = (r_div >= i_prescale);
  assign o_tick = i_run && w_hit;

  always_ff @(posedge clock0) begin
    if (reset || i_clear || !i_run) begin
      r_div <= '0;
    end else if (w_hit) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/up_counter16_ctrl.sv
// Programmable up counter (wrap / one-shot) with registered tc and match pulses; start->running in 1 cycle.
// Optional tick prescaler under UP_COUNTER16_PRESCALE_EN; commands are pulses, no backpressure.
module up_counter16_ctrl
  import up_counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic               clock0,
  input  logic               reset,
  up_counter16_ctrl_if.slave bus
);

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_count,      w_count_nxt;
  logic [WIDTH-1:0] r_limit_q,    w_limit_nxt;
  logic             r_one_shot_q, w_one_shot_nxt;
  logic             r_tc,         w_tc_nxt;
  logic             r_match,      w_match_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] w_count_inc;

`ifdef UP_COUNTER16_PRESCALE_EN
  logic w_run;
  logic w_clear;

  assign w_run   = (r_state == ST_RUN);
  assign w_clear = bus.start || bus.stop;

  up_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clock0     (clock0),
    .reset      (reset),
    .i_run      (w_run),
    .i_clear    (w_clear),
    .i_prescale (bus.prescale),
    .o_tick     (w_tick)
  );
`else
  logic [PRESCALE_W-1:0] w_unused_prescale;

  assign w_unused_prescale = bus.prescale;
  assign w_tick            = (r_state == ST_RUN);
`endif

  assign w_count_inc = WIDTH'(r_count + 1'b1);

  always_ff @(posedge clock0) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_limit_q    <= '0;
      r_one_shot_q <= 1'b0;
      r_tc         <= 1'b0;
      r_match      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_limit_q    <= w_limit_nxt;
      r_one_shot_q <= w_one_shot_nxt;
      r_tc         <= w_tc_nxt;
      r_match      <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_limit_nxt    = r_limit_q;
    w_one_shot_nxt = r_one_shot_q;
    w_tc_nxt       = 1'b0;
    w_match_nxt    = 1'b0;

    if (bus.stop && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.start) begin
      w_state_nxt    = ST_RUN;
      w_count_nxt    = '0;
      w_limit_nxt    = bus.limit;
      w_one_shot_nxt = bus.one_shot;
    end else if (w_tick) begin
      if (r_count == r_limit_q) begin
        w_tc_nxt = 1'b1;
        if (r_one_shot_q) begin
          // Count does not change on completion, so no match pulse here.
          w_state_nxt = ST_DONE;
        end else begin
          w_count_nxt = '0;
          w_match_nxt = (bus.cmp_val == '0);
        end
      end else begin
        w_count_nxt = w_count_inc;
        w_match_nxt = (w_count_inc == bus.cmp_val);
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.running = (r_state == ST_RUN);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.tc      = r_tc;
  assign bus.match   = r_match;

endmodule
